// File: rtl/vector_hadamard_tiled.sv
// Element-wise signed fixed-point multiply of two packed vectors, TILING lanes per
// clock, with floor shift by FRACTION and saturation to RESULT_CELL_WIDTH.
module vector_hadamard_tiled #(
  parameter int VECTOR_LEN        = 5,
  parameter int A_CELL_WIDTH      = 8,
  parameter int B_CELL_WIDTH      = 8,
  parameter int RESULT_CELL_WIDTH = 8,
  parameter int FRACTION          = 4,
  parameter int TILING            = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic [VECTOR_LEN*A_CELL_WIDTH-1:0]      a,
  input  logic [VECTOR_LEN*B_CELL_WIDTH-1:0]      b,
  output logic [VECTOR_LEN*RESULT_CELL_WIDTH-1:0] result,
  output logic                                    valid,
  output logic                                    busy
);

  localparam int NUM_TILES = (VECTOR_LEN + TILING - 1) / TILING;
  localparam int TILE_W    = $clog2(NUM_TILES + 1);
  localparam int PROD_W    = A_CELL_WIDTH + B_CELL_WIDTH;

  localparam logic [TILE_W-1:0] LAST_TILE = TILE_W'(NUM_TILES - 1);
  localparam logic [TILE_W-1:0] END_TILE  = TILE_W'(NUM_TILES);

  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((1 << (RESULT_CELL_WIDTH - 1)) - 1);
  localparam logic signed [PROD_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [VECTOR_LEN*A_CELL_WIDTH-1:0] a_q;
  logic [VECTOR_LEN*B_CELL_WIDTH-1:0] b_q;

  // tile_q is the next tile fed to the multipliers; the stage register holds the
  // saturated products of one tile until they are written into result.
  logic [TILE_W-1:0] tile_q;
  logic              stg_vld_q;
  logic [TILE_W-1:0] stg_tile_q;
  logic signed [RESULT_CELL_WIDTH-1:0] stg_q [TILING];

  logic signed [A_CELL_WIDTH-1:0]      lane_a   [TILING];
  logic signed [B_CELL_WIDTH-1:0]      lane_b   [TILING];
  logic signed [RESULT_CELL_WIDTH-1:0] lane_sat [TILING];

  logic issue;
  assign issue = (state_q == RUN) && (tile_q != END_TILE);

  // Operand mux: route the elements of the current tile onto the TILING lanes.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    lane_a = '{default: '0};
    lane_b = '{default: '0};
    for (int e = 0; e < VECTOR_LEN; e++) begin
      if (tile_q == TILE_W'(e / TILING)) begin
        lane_a[e % TILING] = a_q[e*A_CELL_WIDTH +: A_CELL_WIDTH];
        lane_b[e % TILING] = b_q[e*B_CELL_WIDTH +: B_CELL_WIDTH];
      end
    end
  end

  for (genvar j = 0; j < TILING; j++) begin : g_lane
    logic signed [PROD_W-1:0] ext_a, ext_b, prod, shifted;

    assign ext_a   = PROD_W'(lane_a[j]);
    assign ext_b   = PROD_W'(lane_b[j]);
    assign prod    = ext_a * ext_b;
    assign shifted = prod >>> FRACTION;

    assign lane_sat[j] = (shifted > SAT_MAX) ? SAT_MAX[RESULT_CELL_WIDTH-1:0] :
                         (shifted < SAT_MIN) ? SAT_MIN[RESULT_CELL_WIDTH-1:0] :
                                               shifted[RESULT_CELL_WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (stg_vld_q && (stg_tile_q == LAST_TILE)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      valid      <= 1'b0;
      busy       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      tile_q     <= '0;
      stg_vld_q  <= 1'b0;
      stg_tile_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q   <= state_d;
      valid     <= (state_d == DONE);
      busy      <= (state_d != IDLE);
      stg_vld_q <= issue;
      if (state_q == IDLE && start) begin
        a_q    <= a;
        b_q    <= b;
        tile_q <= '0;
      end
      if (issue) begin
        stg_tile_q <= tile_q;
        tile_q     <= tile_q + TILE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: this small register array is reset along with the rest so an
      // aborted operation can never leak stale products into result.
      stg_q <= '{default: '0};
    end else if (issue) begin
      stg_q <= lane_sat;
    end
  end

  // Elements beyond VECTOR_LEN in a partial last tile have no slot and are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result <= '0;
    end else if (stg_vld_q) begin
      for (int e = 0; e < VECTOR_LEN; e++) begin
        if (stg_tile_q == TILE_W'(e / TILING))
          result[e*RESULT_CELL_WIDTH +: RESULT_CELL_WIDTH] <= stg_q[e % TILING];
      end
    end
  end

endmodule
